// File: rtl/sprom_arbiter.sv
// rtl/sprom_arbiter.sv - two-port round-robin read sequencer for a single synchronous ROM
module sprom_arbiter #(
  parameter int AWIDTH = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  output logic [1:0]        ack,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [15:0]       rom_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0] state;
  logic       gnt;
  logic       last_grant;
  logic [1:0] eligible;
  logic       pick;

  // The requester being acked this cycle still has req high; masking it lets
  // the other side win the ack cycle and keeps a held req from double-reading.
  always_comb begin
    eligible = req & ~ack;
    pick     = 1'b0;
    case (eligible)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
  end

  assign busy = (state == S_ISSUE) || (state == S_WAIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ack        <= 2'b00;
      rdata      <= 16'h0000;
      rom_addr   <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      ack <= 2'b00;
      case (state)
        S_IDLE: begin
          if (eligible != 2'b00) begin
            rom_addr   <= pick ? addr1 : addr0;
            gnt        <= pick;
            last_grant <= pick;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          rdata <= rom_q;
          ack   <= gnt ? 2'b10 : 2'b01;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprom_arbiter.sv
// tb/tb_sprom_arbiter.sv - self-checking bench for sprom_arbiter with a 4-bit ROM model
module tb_sprom_arbiter;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [1:0]    ack;
  logic [15:0]   rdata;
  logic          busy;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_q;
  logic [AW-1:0] rom_areg = '0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // ROM: registered address, combinational word k ^ A5A5
  always @(posedge clock) rom_areg <= rom_addr;
  assign rom_q = {12'h000, rom_areg} ^ 16'hA5A5;

  sprom_arbiter #(.AWIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .addr0(addr0), .addr1(addr1),
    .ack(ack), .rdata(rdata), .busy(busy), .rom_addr(rom_addr), .rom_q(rom_q)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    rq;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [1:0]    e_ack;
    logic [15:0]   e_rdata;
    logic          e_busy;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Transaction-schedule reference: a grant at edge g gives busy after g and g+1,
  // ack and data after g+2, and the arbiter can grant again at edge g+3.
  int            cyc;
  int            m_g;
  logic          m_who;
  logic          m_last;
  logic [1:0]    m_ack;
  logic [15:0]   m_data;
  logic [15:0]   m_rdata;
  logic [AW-1:0] m_addr;
  logic          m_busy;

  task automatic model_reset();
    cyc = 0; m_g = -100; m_who = 1'b0; m_last = 1'b1; m_ack = 2'b00;
    m_data = 16'h0; m_rdata = 16'h0; m_addr = '0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    int e;
    logic [1:0] elig;
    e = cyc + 1;
    if (e >= m_g + 3) begin
      elig = req & ~m_ack;
      if (elig != 2'b00) begin
        m_who  = (elig == 2'b11) ? ~m_last : elig[1];
        m_last = m_who;
        m_g    = e;
        m_addr = m_who ? addr1 : addr0;
        m_data = {12'h000, m_addr} ^ 16'hA5A5;
      end
    end
    m_ack = (e == m_g + 2) ? (m_who ? 2'b10 : 2'b01) : 2'b00;
    if (e == m_g + 2) m_rdata = m_data;
    m_busy = (e == m_g) || (e == m_g + 1);
    cyc = e;
  endtask

  initial begin
    int nacks;
    int last_ack_cyc;
    logic [1:0] exp_ack;

    tbl[0]  = '{1'b1, 2'b11, 4'd2, 4'd5, 2'b00, 16'h0000, 1'b1};
    tbl[1]  = '{1'b0, 2'b11, 4'd2, 4'd5, 2'b00, 16'h0000, 1'b1};
    tbl[2]  = '{1'b0, 2'b11, 4'd2, 4'd5, 2'b01, 16'hA5A7, 1'b0};
    tbl[3]  = '{1'b0, 2'b10, 4'd2, 4'd5, 2'b00, 16'hA5A7, 1'b1};
    tbl[4]  = '{1'b0, 2'b10, 4'd2, 4'd5, 2'b00, 16'hA5A7, 1'b1};
    tbl[5]  = '{1'b0, 2'b10, 4'd2, 4'd5, 2'b10, 16'hA5A0, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 4'd2, 4'd5, 2'b00, 16'hA5A0, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 4'd3, 4'd0, 2'b00, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 2'b01, 4'd3, 4'd0, 2'b00, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 2'b01, 4'd3, 4'd0, 2'b01, 16'hA5A6, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 4'd3, 4'd0, 2'b00, 16'hA5A6, 1'b0};
    tbl[11] = '{1'b0, 2'b01, 4'd1, 4'd0, 2'b00, 16'hA5A6, 1'b1};
    tbl[12] = '{1'b0, 2'b01, 4'd9, 4'd0, 2'b00, 16'hA5A6, 1'b1};
    tbl[13] = '{1'b0, 2'b01, 4'd9, 4'd0, 2'b01, 16'hA5A4, 1'b0};
    tbl[14] = '{1'b0, 2'b00, 4'd9, 4'd0, 2'b00, 16'hA5A4, 1'b0};
    tbl[15] = '{1'b0, 2'b10, 4'd0, 4'd0, 2'b00, 16'hA5A4, 1'b1};
    tbl[16] = '{1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 16'hA5A4, 1'b1};
    tbl[17] = '{1'b0, 2'b00, 4'd0, 4'd0, 2'b10, 16'hA5A5, 1'b0};
    tbl[18] = '{1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 16'hA5A5, 1'b0};
    tbl[19] = '{1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 16'hA5A5, 1'b0};

    @(negedge clock);
    do_reset();
    chk("reset_ack", ack, 2'b00);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rom_addr", rom_addr, 4'd0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) do_reset();
      req = tbl[i].rq; addr0 = tbl[i].a0; addr1 = tbl[i].a1;
      @(negedge clock);
      chk($sformatf("vec%0d_ack", i), ack, tbl[i].e_ack);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Sustained contention: both sides held high, grants must alternate 0,1,...
    do_reset();
    req = 2'b11; addr0 = 4'd4; addr1 = 4'd6;
    nacks = 0; last_ack_cyc = 0;
    for (int c = 1; c <= 60 && nacks < 12; c++) begin
      @(negedge clock);
      if (ack != 2'b00) begin
        exp_ack = (nacks % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("rr_ack%0d", nacks), ack, exp_ack);
        chk($sformatf("rr_rdata%0d", nacks), rdata, (nacks % 2 == 0) ? 16'hA5A1 : 16'hA5A3);
        if (nacks > 0) chk($sformatf("rr_spacing%0d", nacks), c - last_ack_cyc, 3);
        last_ack_cyc = c;
        nacks++;
      end
    end
    chk("rr_ack_count", nacks, 12);
    req = 2'b00;
    repeat (4) @(negedge clock);

    // Reset asserted during WAIT aborts the read immediately
    req = 2'b01; addr0 = 4'd3;
    @(negedge clock);
    @(negedge clock);
    chk("abort_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_ack", ack, 2'b00);
    chk("abort_rdata", rdata, 16'h0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rom_addr", rom_addr, 4'd0);
    @(negedge clock);
    reset_n = 1'b1;
    req = 2'b00;
    @(negedge clock);
    chk("abort_no_ack", ack, 2'b00);
    req = 2'b10; addr1 = 4'd7;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("after_abort_ack", ack, 2'b10);
    chk("after_abort_rdata", rdata, 16'hA5A2);
    req = 2'b00;
    @(negedge clock);

    // Randomized traffic against the schedule model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if (!(req[0] && !ack[0] && $urandom_range(9) != 0)) begin
        req[0] = ($urandom_range(2) != 0);
        addr0 = AW'($urandom_range(15));
      end
      if (!(req[1] && !ack[1] && $urandom_range(9) != 0)) begin
        req[1] = ($urandom_range(2) != 0);
        addr1 = AW'($urandom_range(15));
      end
      model_step();
      @(negedge clock);
      chk($sformatf("rnd%0d_ack", c), ack, m_ack);
      chk($sformatf("rnd%0d_busy", c), busy, m_busy);
      chk($sformatf("rnd%0d_rdata", c), rdata, m_rdata);
      chk($sformatf("rnd%0d_rom_addr", c), rom_addr, m_addr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
